// File: rtl/dm_ctrl_pkg.sv
// Shared pipeline definitions for the data-memory controller: bus word type,
// default geometry and the controller FSM state encoding.
package dm_ctrl_pkg;

    localparam int REG_W       = 32;
    localparam int DM_AW_DEF   = 14;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W       = 8;

    typedef logic [REG_W-1:0] reg_bus_t;

    localparam reg_bus_t ZERO_WORD    = '0;
    localparam logic     READ_ENABLE  = 1'b1;
    localparam logic     WRITE_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } dm_state_e;

endpackage

// File: rtl/dm_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
interface dm_ctrl_if
    import dm_ctrl_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEF
) ();

    logic             dm_cs;
    logic             dm_we;
    logic [DM_AW-1:0] dm_addr;
    reg_bus_t         dm_wdata;
    reg_bus_t         dm_rdata;
    logic             dm_ack;

    modport master (
        output dm_cs,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ack
    );

    modport slave (
        input  dm_cs,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ack
    );

endinterface

// File: rtl/dm_ctrl.sv
// MEM-stage data-memory controller: issues word loads/stores, stalls the
// pipeline until dm_ack or timeout, and reports misaligned/conflicting accesses.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int DM_AW   = DM_AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      mem_DM_read,
    input  logic      mem_DM_write,
    input  reg_bus_t  mem_alu_result,
    input  reg_bus_t  mem_sw_o,
    output logic      mem_stall,
    output reg_bus_t  mem_lw_data,
    output logic      mem_lw_valid,
    output logic      mem_dm_err,
    dm_ctrl_if.master dm
);

    // The request cycle in IDLE is the first wait cycle, so the last READ/WRITE
    // cycle before timeout is the one where the counter holds TIMEOUT-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    dm_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    logic aligned;
    logic req_rd;
    logic req_wr;
    logic req_bad;
    logic in_access;
    logic issue;
    logic unused_addr_bits;

    always_comb begin
        aligned   = (mem_alu_result[1:0] == 2'b00);
        req_rd    = mem_DM_read & ~mem_DM_write & aligned;
        req_wr    = mem_DM_write & ~mem_DM_read & aligned;
        req_bad   = (mem_DM_read | mem_DM_write) & ~(req_rd | req_wr);
        in_access = (state == READ) || (state == WRITE);
        issue     = (state == IDLE) && (req_rd || req_wr);
    end

    // Reset gates the combinational strobes so an in-flight access drops at once.
    always_comb begin
        dm.dm_cs    = ~rst & (issue | in_access);
        dm.dm_we    = ~rst & (((state == IDLE) & req_wr) | (state == WRITE));
        dm.dm_addr  = mem_alu_result[DM_AW+1:2];
        dm.dm_wdata = mem_sw_o;
        mem_stall   = ~rst & (issue | in_access);
        mem_dm_err  = ~rst & (err_q | ((state == IDLE) & req_bad));
    end

    assign unused_addr_bits = ^{mem_alu_result[REG_W-1:DM_AW+2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_lw_data  <= ZERO_WORD;
            mem_lw_valid <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_lw_valid <= 1'b0;
            err_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt <= '0;
                        if (dm.dm_ack) begin
                            state        <= RESP;
                            mem_lw_valid <= req_rd;
                            if (req_rd) begin
                                mem_lw_data <= dm.dm_rdata;
                            end
                        end else begin
                            state <= req_rd ? READ : WRITE;
                        end
                    end
                end
                READ, WRITE: begin
                    if (dm.dm_ack) begin
                        state        <= RESP;
                        mem_lw_valid <= (state == READ);
                        if (state == READ) begin
                            mem_lw_data <= dm.dm_rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state        <= RESP;
                        err_q        <= 1'b1;
                        mem_lw_valid <= (state == READ);
                        if (state == READ) begin
                            mem_lw_data <= ZERO_WORD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed self-checking bench for dm_ctrl with a behavioural memory driver.
module tb_dm_ctrl;
    import dm_ctrl_pkg::*;

    logic     clk;
    logic     rst;
    logic     mem_DM_read;
    logic     mem_DM_write;
    reg_bus_t mem_alu_result;
    reg_bus_t mem_sw_o;
    logic     mem_stall;
    reg_bus_t mem_lw_data;
    logic     mem_lw_valid;
    logic     mem_dm_err;

    int n_checks = 0;
    int n_fail   = 0;

    dm_ctrl_if #(.DM_AW(14)) bus ();

    dm_ctrl #(
        .DM_AW   (14),
        .TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_DM_read    (mem_DM_read),
        .mem_DM_write   (mem_DM_write),
        .mem_alu_result (mem_alu_result),
        .mem_sw_o       (mem_sw_o),
        .mem_stall      (mem_stall),
        .mem_lw_data    (mem_lw_data),
        .mem_lw_valid   (mem_lw_valid),
        .mem_dm_err     (mem_dm_err),
        .dm             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one load/store starting at posedge+1; ack_at is the 1-based stall
    // cycle carrying dm_ack (0 = never). Returns the values seen in RESP.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_at, input logic [31:0] rdata,
                          output int stalls, output logic r_valid, output logic r_err,
                          output logic r_cs, output logic [31:0] r_data);
        logic done;
        logic [31:0] exp_addr;
        exp_addr       = (addr >> 2) & 32'h3FFF;
        mem_DM_read    = ~wr;
        mem_DM_write   = wr;
        mem_alu_result = addr;
        mem_sw_o       = wdata;
        stalls  = 0;
        done    = 1'b0;
        r_valid = 1'b0;
        r_err   = 1'b0;
        r_cs    = 1'b0;
        r_data  = '0;
        for (int c = 1; c <= 300 && !done; c++) begin
            bus.dm_ack   = (c == ack_at);
            bus.dm_rdata = (c == ack_at) ? rdata : 32'h5A5A_5A5A;
            @(negedge clk);
            if (mem_stall) begin
                stalls++;
                chk("cs_in_access", {31'b0, bus.dm_cs}, 32'd1);
                chk("we_in_access", {31'b0, bus.dm_we}, {31'b0, wr});
                chk("addr_in_access", {18'b0, bus.dm_addr}, exp_addr);
                if (wr) chk("wdata_in_access", bus.dm_wdata, wdata);
            end else begin
                r_valid = mem_lw_valid;
                r_err   = mem_dm_err;
                r_cs    = bus.dm_cs;
                r_data  = mem_lw_data;
                done    = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("access_completed", {31'b0, done}, 32'd1);
        bus.dm_ack   = 1'b0;
        mem_DM_read  = 1'b0;
        mem_DM_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          st;
        logic        v, e, cs;
        logic [31:0] d;

        rst            = 1'b1;
        mem_DM_read    = 1'b1;
        mem_DM_write   = 1'b0;
        mem_alu_result = 32'h10;
        mem_sw_o       = '0;
        bus.dm_ack     = 1'b0;
        bus.dm_rdata   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", {31'b0, bus.dm_cs}, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_err", {31'b0, mem_dm_err}, 32'd0);
        chk("rst_valid", {31'b0, mem_lw_valid}, 32'd0);
        chk("rst_lw_data", mem_lw_data, 32'h0);
        mem_DM_read = 1'b0;
        rst         = 1'b0;

        // Load with ack in 3rd stall cycle
        access(1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, st, v, e, cs, d);
        chk("ld_stalls", st, 32'd3);
        chk("ld_valid", {31'b0, v}, 32'd1);
        chk("ld_data", d, 32'hDEAD_BEEF);
        chk("ld_err", {31'b0, e}, 32'd0);
        chk("ld_resp_cs", {31'b0, cs}, 32'd0);

        // Store acked in the request cycle
        access(1'b1, 32'h20, 32'h1234_5678, 1, 32'h0, st, v, e, cs, d);
        chk("st_stalls", st, 32'd1);
        chk("st_valid", {31'b0, v}, 32'd0);
        chk("st_data_kept", d, 32'hDEAD_BEEF);
        chk("st_err", {31'b0, e}, 32'd0);

        // Stray ack while idle is ignored
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("stray_cs", {31'b0, bus.dm_cs}, 32'd0);
        @(posedge clk);
        #1;
        bus.dm_ack = 1'b0;
        @(negedge clk);
        chk("stray_data", mem_lw_data, 32'hDEAD_BEEF);
        chk("stray_valid", {31'b0, mem_lw_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Misaligned load, then read+write conflict
        mem_DM_read    = 1'b1;
        mem_alu_result = 32'h6;
        @(negedge clk);
        chk("mis_err", {31'b0, mem_dm_err}, 32'd1);
        chk("mis_cs", {31'b0, bus.dm_cs}, 32'd0);
        chk("mis_stall", {31'b0, mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        mem_DM_write   = 1'b1;
        mem_alu_result = 32'h10;
        @(negedge clk);
        chk("both_err", {31'b0, mem_dm_err}, 32'd1);
        chk("both_cs", {31'b0, bus.dm_cs}, 32'd0);
        chk("both_stall", {31'b0, mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        mem_DM_read  = 1'b0;
        mem_DM_write = 1'b0;
        @(negedge clk);
        chk("idle_err_clear", {31'b0, mem_dm_err}, 32'd0);
        @(posedge clk);
        #1;

        // Timeout: no ack
        access(1'b0, 32'h40, 32'h0, 0, 32'h0, st, v, e, cs, d);
        chk("to_stalls", st, 32'd16);
        chk("to_err", {31'b0, e}, 32'd1);
        chk("to_data", d, 32'h0);
        @(negedge clk);
        chk("to_err_one_cycle", {31'b0, mem_dm_err}, 32'd0);
        @(posedge clk);
        #1;

        // Ack coincides with the timeout cycle: normal completion wins
        access(1'b0, 32'h44, 32'h0, 16, 32'h7777_8888, st, v, e, cs, d);
        chk("edge_stalls", st, 32'd16);
        chk("edge_err", {31'b0, e}, 32'd0);
        chk("edge_valid", {31'b0, v}, 32'd1);
        chk("edge_data", d, 32'h7777_8888);

        // Reset in the 2nd READ cycle
        mem_DM_read    = 1'b1;
        mem_alu_result = 32'h10;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_cs", {31'b0, bus.dm_cs}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_cs", {31'b0, bus.dm_cs}, 32'd0);
        chk("abort_stall", {31'b0, mem_stall}, 32'd0);
        chk("abort_lw_data", mem_lw_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(1'b0, 32'h80, 32'h0, 2, 32'hCAFE_F00D, st, v, e, cs, d);
        chk("post_rst_stalls", st, 32'd2);
        chk("post_rst_valid", {31'b0, v}, 32'd1);
        chk("post_rst_data", d, 32'hCAFE_F00D);
        chk("post_rst_err", {31'b0, e}, 32'd0);

        // Back-to-back load then store
        access(1'b0, 32'h100, 32'h0, 1, 32'h1111_2222, st, v, e, cs, d);
        chk("b2b_ld_stalls", st, 32'd1);
        chk("b2b_ld_valid", {31'b0, v}, 32'd1);
        chk("b2b_ld_data", d, 32'h1111_2222);
        chk("b2b_ld_resp_cs", {31'b0, cs}, 32'd0);
        access(1'b1, 32'h104, 32'hABCD_EF01, 1, 32'h0, st, v, e, cs, d);
        chk("b2b_st_stalls", st, 32'd1);
        chk("b2b_st_valid", {31'b0, v}, 32'd0);
        chk("b2b_st_data_kept", d, 32'h1111_2222);
        chk("b2b_st_resp_cs", {31'b0, cs}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
